// File: rtl/mem_stage.sv
// Memory stage: retires ALU-only instructions in one edge and runs loads/stores
// through a fixed wait of LATENCY cycles against a word-addressed data memory.
module mem_stage #(
  parameter int SIZE    = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2,
  localparam int W = $clog2(SIZE) + 4*SIZE + 10,
  localparam int V = $clog2(SIZE) + 2*SIZE + 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [W-1:0]    EX_MEM,
  input  logic            EX_MEM_valid,
  output logic            stall,
  output logic [V-1:0]    MEM_WB,
  output logic            MEM_WB_valid,
  output logic            PCSrc,
  output logic [SIZE-1:0] branchTarget
);

  // state  | meaning
  // IDLE   | ready; ALU-only instructions retire directly from here
  // ACCESS | waiting out the memory latency, cnt counts down to 1
  // DONE   | memory operation performed on the next edge, then retire
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [W-1:0]      bundle_q, bundle_d;
  logic [V-1:0]      mem_wb_q, mem_wb_d;
  logic              valid_q, valid_d;
  logic              pcsrc_q, pcsrc_d;
  logic [SIZE-1:0]   bt_q, bt_d;

  logic [SIZE-1:0]   mem [DEPTH];
  logic [AW-1:0]     mem_addr;
  logic [SIZE-1:0]   rd_data;
  logic              mem_we;
  logic              retire;
  logic [W-1:0]      ret_bundle;
  logic [SIZE-1:0]   ret_load;
  logic              unused_fields;

  assign mem_addr = bundle_q[SIZE+11+AW : SIZE+12];
  assign rd_data  = mem[mem_addr];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bundle_d   = bundle_q;
    mem_wb_d   = mem_wb_q;
    valid_d    = 1'b0;
    pcsrc_d    = 1'b0;
    bt_d       = bt_q;
    mem_we     = 1'b0;
    retire     = 1'b0;
    ret_bundle = EX_MEM;
    ret_load   = '0;
    case (state_q)
      IDLE: begin
        if (EX_MEM_valid) begin
          if (EX_MEM[7] || EX_MEM[2]) begin
            bundle_d = EX_MEM;
            cnt_d    = CW'(LATENCY);
            state_d  = ACCESS;
          end else begin
            retire = 1'b1;
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        retire     = 1'b1;
        ret_bundle = bundle_q;
        // a combined read+write performs only the write and returns zero
        ret_load   = (bundle_q[7] && !bundle_q[2]) ? rd_data : '0;
        mem_we     = rst_n && bundle_q[2];
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (retire) begin
      mem_wb_d = {ret_bundle[W-1:4*SIZE+10], ret_bundle[2*SIZE+9:SIZE+10],
                  ret_load, ret_bundle[5], ret_bundle[6]};
      valid_d  = 1'b1;
      pcsrc_d  = ret_bundle[9] | (ret_bundle[8] & ret_bundle[0]);
      bt_d     = ret_bundle[3*SIZE+9:2*SIZE+10];
    end
  end

  assign unused_fields = ^{ret_bundle[4:3], ret_bundle[1], ret_bundle[4*SIZE+9:3*SIZE+10]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bundle_q <= '0;
      mem_wb_q <= '0;
      valid_q  <= 1'b0;
      pcsrc_q  <= 1'b0;
      bt_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bundle_q <= bundle_d;
      mem_wb_q <= mem_wb_d;
      valid_q  <= valid_d;
      pcsrc_q  <= pcsrc_d;
      bt_q     <= bt_d;
    end
  end

  // data memory keeps its contents across reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= bundle_q[SIZE+9:10];
  end

  assign stall        = (state_q != IDLE);
  assign MEM_WB       = mem_wb_q;
  assign MEM_WB_valid = valid_q;
  assign PCSrc        = pcsrc_q;
  assign branchTarget = bt_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized and directed bench for mem_stage, checked against a field-level
// model of the stage with an array standing in for the data memory.
module tb_mem_stage;
  localparam int SIZE    = 32;
  localparam int DEPTH   = 256;
  localparam int LATENCY = 2;
  localparam int W = $clog2(SIZE) + 4*SIZE + 10;
  localparam int V = $clog2(SIZE) + 2*SIZE + 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [W-1:0]    ex_mem;
  logic            ex_mem_valid;
  logic            stall;
  logic [V-1:0]    mem_wb;
  logic            mem_wb_valid;
  logic            pcsrc;
  logic [SIZE-1:0] branch_target;

  int tests_run = 0;
  int tests_failed = 0;
  logic [SIZE-1:0] ref_mem [DEPTH];
  logic [SIZE-1:0] held_bt;

  mem_stage #(.SIZE(SIZE), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst_n(rst_n), .EX_MEM(ex_mem), .EX_MEM_valid(ex_mem_valid),
    .stall(stall), .MEM_WB(mem_wb), .MEM_WB_valid(mem_wb_valid),
    .PCSrc(pcsrc), .branchTarget(branch_target)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [9:0] ctrl, input logic [31:0] sd,
                                      input logic [31:0] alu, input logic [31:0] tgt,
                                      input logic [31:0] pc, input logic [4:0] wr);
    return {wr, pc, tgt, alu, sd, ctrl};
  endfunction

  task automatic run(input string tag, input logic [W-1:0] b, input bit scramble);
    logic [9:0]  c;
    logic [31:0] sd, alu, tgt, ld;
    logic [4:0]  wr;
    int unsigned idx;
    bit          memop;
    int          lat, stalls, exp_lat;
    c   = b[9:0];
    sd  = b[41:10];
    alu = b[73:42];
    tgt = b[105:74];
    wr  = b[142:138];
    memop = c[7] | c[2];
    idx = (alu / 4) % DEPTH;
    ld = 32'h0;
    if (c[7] && !c[2]) ld = ref_mem[idx];
    exp_lat = memop ? LATENCY + 1 : 0;

    @(negedge clk);
    ex_mem = b;
    ex_mem_valid = 1'b1;
    @(posedge clk); #1;
    if (scramble) ex_mem = W'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    lat = 0;
    stalls = 0;
    while (!mem_wb_valid && lat < 20) begin
      if (stall) stalls++;
      @(posedge clk); #1;
      lat++;
    end
    ex_mem_valid = 1'b0;
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_stall_cycles"}, stalls, memop ? LATENCY + 1 : 0);
    chk({tag, "_stall_at_retire"}, stall, 1'b0);
    chk({tag, "_mem_wb"}, mem_wb, {wr, alu, ld, c[5], c[6]});
    chk({tag, "_pcsrc"}, pcsrc, c[9] | (c[8] & c[0]));
    chk({tag, "_branch_target"}, branch_target, tgt);
    if (c[2]) ref_mem[idx] = sd;
    held_bt = tgt;
  endtask

  task automatic idle(input string tag, input int n);
    ex_mem_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      chk({tag, "_idle_valid"}, mem_wb_valid, 1'b0);
      chk({tag, "_idle_pcsrc"}, pcsrc, 1'b0);
      chk({tag, "_idle_stall"}, stall, 1'b0);
      chk({tag, "_idle_bt_hold"}, branch_target, held_bt);
    end
  endtask

  task automatic abort(input string tag, input logic [W-1:0] b, input int edges_before);
    @(negedge clk);
    ex_mem = b;
    ex_mem_valid = 1'b1;
    @(posedge clk); #1;
    ex_mem_valid = 1'b0;
    chk({tag, "_stall_after_capture"}, stall, 1'b1);
    repeat (edges_before) begin
      @(posedge clk); #1;
      chk({tag, "_no_early_valid"}, mem_wb_valid, 1'b0);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_rst_valid"}, mem_wb_valid, 1'b0);
    chk({tag, "_rst_mem_wb"}, mem_wb, '0);
    chk({tag, "_rst_pcsrc"}, pcsrc, 1'b0);
    chk({tag, "_rst_bt"}, branch_target, '0);
    chk({tag, "_rst_stall"}, stall, 1'b0);
    held_bt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(tag, 4);
  endtask

  initial begin
    logic [9:0]  c;
    logic [31:0] alu;
    int unsigned idx;
    rst_n = 1'b0;
    ex_mem = '0;
    ex_mem_valid = 1'b0;
    held_bt = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_stall", stall, 1'b0);
    chk("reset_valid", mem_wb_valid, 1'b0);
    chk("reset_mem_wb", mem_wb, '0);
    chk("reset_pcsrc", pcsrc, 1'b0);
    chk("reset_bt", branch_target, '0);
    @(negedge clk);
    rst_n = 1'b1;

    run("alu_only", mk(10'h020, 32'h0, 32'h0000_0010, 32'h0, 32'h0, 5'd5), 1'b0);
    run("alu_b2b", mk(10'h060, 32'h0, 32'h0000_0abc, 32'h0, 32'h4, 5'd9), 1'b0);
    run("store_8", mk(10'h004, 32'hDEAD_BEEF, 32'h0000_0008, 32'h0, 32'h8, 5'd0), 1'b0);
    run("load_8", mk(10'h0E0, 32'h0, 32'h0000_0008, 32'h0, 32'hC, 5'd7), 1'b0);
    run("store_wrap", mk(10'h004, 32'h1234_5678, 32'h0000_0403, 32'h0, 32'h10, 5'd0), 1'b0);
    run("load_wrap", mk(10'h0E0, 32'h0, 32'h0000_0000, 32'h0, 32'h14, 5'd3), 1'b0);
    run("branch_taken", mk(10'h101, 32'h0, 32'h0, 32'h0000_0040, 32'h18, 5'd0), 1'b0);
    run("branch_not", mk(10'h100, 32'h0, 32'h0, 32'h0000_0080, 32'h1C, 5'd0), 1'b0);
    idle("after_branch", 2);
    run("jump", mk(10'h200, 32'h0, 32'h0, 32'h0000_0100, 32'h20, 5'd0), 1'b0);
    run("rd_wr_both", mk(10'h0E4, 32'hCAFE_F00D, 32'h0000_0020, 32'h0, 32'h24, 5'd4), 1'b0);
    run("load_after_both", mk(10'h0E0, 32'h0, 32'h0000_0020, 32'h0, 32'h28, 5'd4), 1'b0);
    run("stall_hold", mk(10'h0E0, 32'h0, 32'h0000_0008, 32'h0, 32'h2C, 5'd11), 1'b1);
    idle("after_hold", 2);

    run("prestore_4", mk(10'h004, 32'h1111_2222, 32'h0000_0004, 32'h0, 32'h30, 5'd0), 1'b0);
    run("prestore_c", mk(10'h004, 32'h3333_4444, 32'h0000_000C, 32'h0, 32'h34, 5'd0), 1'b0);
    abort("abort_access", mk(10'h004, 32'hAAAA_AAAA, 32'h0000_0004, 32'h77, 32'h38, 5'd0), 0);
    run("load_4_after_abort", mk(10'h0E0, 32'h0, 32'h0000_0004, 32'h0, 32'h3C, 5'd1), 1'b0);
    abort("abort_done", mk(10'h004, 32'hAAAA_AAAA, 32'h0000_000C, 32'h99, 32'h40, 5'd0), LATENCY);
    run("load_c_after_abort", mk(10'h0E0, 32'h0, 32'h0000_000C, 32'h0, 32'h44, 5'd2), 1'b0);

    for (int i = 0; i < 16; i++)
      run("preinit", mk(10'h004, $urandom(), 32'(i * 4), 32'h0, 32'h0, 5'd0), 1'b0);
    for (int i = 0; i < 80; i++) begin
      c = 10'($urandom_range(0, 1023));
      idx = $urandom_range(0, 15);
      alu = ($urandom() & 32'hFFFF_FC00) | (idx << 2) | 32'($urandom_range(0, 3));
      run("random", mk(c, $urandom(), alu, $urandom(), $urandom(), 5'($urandom_range(0, 31))),
          1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle("random_gap", 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
